// File: rtl/cmos_capture_gate.sv
// CMOS front end: registers the sensor bus, blanks the first FRAME_SKIP frames, measures frames per second.
// Latency 2 cycles, identical on vsync/href/data; free-running stream, no backpressure.
module cmos_capture_gate #(
   parameter int FRAME_SKIP = 10,
   parameter int CLK_FREQ   = 24_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       image_in_vsync,
   input  logic       image_in_href,
   input  logic [7:0] image_in_data,
   output logic       image_out_vsync,
   output logic       image_out_href,
   output logic [7:0] image_out_data,
   output logic       frame_valid,
   output logic [7:0] cmos_fps_rate
);
   localparam logic [7:0]  SKIP    = 8'(FRAME_SKIP);
   localparam logic [31:0] SEC_MAX = 32'(CLK_FREQ - 1);

   logic        s1_vsync;
   logic        s1_href;
   logic [7:0]  s1_data;
   logic        s2_vsync;
   logic        s1_live;
   logic [7:0]  frame_cnt;
   logic [7:0]  win_cnt;
   logic [31:0] sec_cnt;
   logic        fall;
   logic        wrap;
   logic [8:0]  fps_sum;

   assign fall    = s2_vsync & ~s1_vsync;
   assign wrap    = (sec_cnt == SEC_MAX);
   assign fps_sum = {1'b0, win_cnt} + {8'd0, fall};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vsync        <= 1'b0;
         s1_href         <= 1'b0;
         s1_data         <= 8'd0;
         s2_vsync        <= 1'b0;
         s1_live         <= 1'b0;
         frame_cnt       <= 8'd0;
         frame_valid     <= 1'b0;
         image_out_vsync <= 1'b0;
         image_out_href  <= 1'b0;
         image_out_data  <= 8'd0;
      end else begin
         s1_vsync <= image_in_vsync;
         s1_href  <= image_in_href;
         s1_data  <= image_in_data;
         s2_vsync <= s1_vsync;
         s1_live  <= 1'b1;
         if (fall && frame_cnt != SKIP)
            frame_cnt <= frame_cnt + 8'd1;
         // s1 must hold a real sample before its low vsync may open the gate,
         // so a frame in flight at reset release is dropped rather than cut.
         if (frame_cnt == SKIP && s1_live && !s1_vsync)
            frame_valid <= 1'b1;
         if (frame_valid) begin
            image_out_vsync <= s1_vsync;
            image_out_href  <= s1_href;
            image_out_data  <= s1_data;
         end else begin
            image_out_vsync <= 1'b0;
            image_out_href  <= 1'b0;
            image_out_data  <= 8'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sec_cnt       <= 32'd0;
         win_cnt       <= 8'd0;
         cmos_fps_rate <= 8'd0;
      end else if (wrap) begin
         // a frame ending on the wrap cycle belongs to the closing window
         sec_cnt       <= 32'd0;
         win_cnt       <= 8'd0;
         cmos_fps_rate <= fps_sum[8] ? 8'hFF : fps_sum[7:0];
      end else begin
         sec_cnt <= sec_cnt + 32'd1;
         if (fall && win_cnt != 8'hFF)
            win_cnt <= win_cnt + 8'd1;
      end
   end
endmodule
